mem_arbiter: RTL

//  Shares the single-port main-memory BRAM between the fetch stage (port 0, IF) and the load/store unit (port 1, LS).

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : shares one single-port RAM between fetch (IF) and load/store
//               (LS), routing each response back after RD_LATENCY cycles.
// Optional    : `define MEM_ARB_PERF_EN adds saturating grant/stall counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int RD_LATENCY    = 1,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  input  logic              if_flush_i,
  output logic              if_rsp_valid_o,
  output logic [31:0]       if_rsp_data_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [3:0]        ls_be_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [31:0]       ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rsp_valid_o,
  output logic [31:0]       ls_rsp_data_o,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]       perf_if_gnt_o,
  output logic [31:0]       perf_ls_gnt_o,
  output logic [31:0]       perf_if_stall_o,
`endif
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam int         LAST       = RD_LATENCY - 1;
  localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

  logic [3:0]            streak_q, streak_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d, src_q, src_d, we_q, we_d, vld_s;
  logic                  if_turn, if_gnt, ls_gnt;

  always_comb begin
    if_turn = if_req_i && (streak_q == STREAK_MAX);
    ls_gnt  = !rst_i && ls_req_i && !if_turn;
    if_gnt  = !rst_i && if_req_i && (!ls_req_i || if_turn);

    if_gnt_o    = if_gnt;
    ls_gnt_o    = ls_gnt;
    mem_req_o   = if_gnt || ls_gnt;
    mem_we_o    = ls_gnt && ls_we_i;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (ls_gnt) begin
      mem_be_o    = ls_we_i ? ls_be_i : 4'hF;
      mem_addr_o  = ls_addr_i;
      mem_wdata_o = ls_wdata_i;
    end else if (if_gnt) begin
      mem_be_o   = 4'hF;
      mem_addr_o = if_addr_i;
    end

    // An LS grant against a waiting IF implies streak_q < MAX, so this never overshoots.
    streak_d = (ls_gnt && if_req_i) ? streak_q + 4'd1 : 4'd0;

    vld_s[0] = if_gnt || ls_gnt;
    src_d[0] = if_gnt;
    we_d[0]  = ls_gnt && ls_we_i;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_s[i] = vld_q[i-1];
      src_d[i] = src_q[i-1];
      we_d[i]  = we_q[i-1];
    end
    vld_d = vld_s & ~(src_d & {RD_LATENCY{if_flush_i}});

    if_rsp_valid_o = !rst_i && vld_q[LAST] && src_q[LAST];
    ls_rsp_valid_o = !rst_i && vld_q[LAST] && !src_q[LAST];
    if_rsp_data_o  = if_rsp_valid_o ? mem_rdata_i : 32'h0;
    ls_rsp_data_o  = (ls_rsp_valid_o && !we_q[LAST]) ? mem_rdata_i : 32'h0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      streak_q <= 4'd0;
      vld_q    <= '0;
      src_q    <= '0;
      we_q     <= '0;
    end else begin
      streak_q <= streak_d;
      vld_q    <= vld_d;
      src_q    <= src_d;
      we_q     <= we_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_gnt_q, perf_if_gnt_d;
  logic [31:0] perf_ls_gnt_q, perf_ls_gnt_d;
  logic [31:0] perf_if_stall_q, perf_if_stall_d;

  always_comb begin
    perf_if_gnt_d   = perf_if_gnt_q;
    perf_ls_gnt_d   = perf_ls_gnt_q;
    perf_if_stall_d = perf_if_stall_q;
    if (if_gnt && perf_if_gnt_q != 32'hFFFF_FFFF)
      perf_if_gnt_d = perf_if_gnt_q + 32'd1;
    if (ls_gnt && perf_ls_gnt_q != 32'hFFFF_FFFF)
      perf_ls_gnt_d = perf_ls_gnt_q + 32'd1;
    if (if_req_i && !if_gnt && perf_if_stall_q != 32'hFFFF_FFFF)
      perf_if_stall_d = perf_if_stall_q + 32'd1;
    perf_if_gnt_o   = perf_if_gnt_q;
    perf_ls_gnt_o   = perf_ls_gnt_q;
    perf_if_stall_o = perf_if_stall_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_if_gnt_q   <= 32'h0;
      perf_ls_gnt_q   <= 32'h0;
      perf_if_stall_q <= 32'h0;
    end else begin
      perf_if_gnt_q   <= perf_if_gnt_d;
      perf_ls_gnt_q   <= perf_ls_gnt_d;
      perf_if_stall_q <= perf_if_stall_d;
    end
  end
`endif

endmodule

`default_nettype wire
